// File: rtl/aes_pkg.sv
// Shared AES types, round constants and key-schedule state encoding.
// Imported by the key schedule and the S-box.
package aes_pkg;

   typedef logic [127:0] aes_block_t;
   typedef logic [31:0]  aes_word_t;

   localparam int AES_NUM_ROUNDS = 10;

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      READY
   } ks_state_t;

   function automatic logic [7:0] rcon_of(input logic [3:0] i);
      logic [7:0] r;
      r = 8'h00;
      for (int k = 1; k <= AES_NUM_ROUNDS; k++) begin
         if (i == 4'(k)) r = RCON[k];
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, 8-bit combinational lookup.
// Shared by the key schedule and the encryption core.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   assign y = SBOX[a];

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion, one round key per cycle, with a combinational read port.
// Define KEY_SCHEDULE_ZEROIZE_EN to add the zeroize input.
module aes_key_schedule
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_NUM_ROUNDS
)
(
   input  logic         clk,
   input  logic         n_rst,
   input  logic         key_load,
   input  logic [127:0] key_in,
   input  logic [3:0]   read_addr,
`ifdef KEY_SCHEDULE_ZEROIZE_EN
   input  logic         zeroize,
`endif
   output logic [127:0] round_key_output,
   output logic [127:0] round_key_0,
   output logic         key_ready,
   output logic         busy
);

   ks_state_t  state, state_nxt;
   aes_block_t store [0:NUM_ROUNDS];
   logic [3:0] cnt;
   logic [3:0] pidx;
   logic       clr;

   aes_block_t prev;
   aes_word_t  p0, p1, p2, p3;
   aes_word_t  rot, sub, t;
   aes_word_t  n0, n1, n2, n3;

`ifdef KEY_SCHEDULE_ZEROIZE_EN
   assign clr = zeroize;
`else
   assign clr = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      key_ready = 1'b0;
      unique case (state)
         IDLE: ;
         EXPAND: begin
            busy = 1'b1;
            if (cnt == 4'(NUM_ROUNDS)) state_nxt = READY;
         end
         READY:   key_ready = 1'b1;
         default: state_nxt = IDLE;
      endcase
      if (key_load) state_nxt = EXPAND;
      if (clr)      state_nxt = IDLE;
   end

   // cnt is 0 only outside EXPAND; clamp so the unused read stays in range
   assign pidx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
   assign prev = store[pidx];
   assign p0   = prev[127:96];
   assign p1   = prev[95:64];
   assign p2   = prev[63:32];
   assign p3   = prev[31:0];
   assign rot  = {p3[23:0], p3[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sub
      aes_sbox u_sbox (
         .a(rot[8*g +: 8]),
         .y(sub[8*g +: 8])
      );
   end

   assign t  = sub ^ {rcon_of(cnt), 24'h0};
   assign n0 = p0 ^ t;
   assign n1 = p1 ^ n0;
   assign n2 = p2 ^ n1;
   assign n3 = p3 ^ n2;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         round_key_0 <= '0;
         for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
      end else begin
         state <= state_nxt;
         if (clr) begin
            cnt         <= 4'd0;
            round_key_0 <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
         end else if (key_load) begin
            store[0]    <= key_in;
            round_key_0 <= key_in;
            cnt         <= 4'd1;
         end else if (state == EXPAND) begin
            store[cnt] <= {n0, n1, n2, n3};
            cnt        <= cnt + 4'd1;
         end
      end
   end

   assign round_key_output = (read_addr <= 4'(NUM_ROUNDS)) ?
                             store[read_addr] : '0;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a FIPS-197 word-level model.
// The model derives its S-box from GF(2^8) inversion plus the affine map.
module tb_aes_key_schedule;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         key_load;
   logic [127:0] key_in;
   logic [3:0]   read_addr;
   logic [127:0] round_key_output;
   logic [127:0] round_key_0;
   logic         key_ready;
   logic         busy;
`ifdef KEY_SCHEDULE_ZEROIZE_EN
   logic         zeroize;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0]   sb [256];
   logic [127:0] exp_rk [11];

   aes_key_schedule dut (
      .clk              (clk),
      .n_rst            (n_rst),
      .key_load         (key_load),
      .key_in           (key_in),
      .read_addr        (read_addr),
`ifdef KEY_SCHEDULE_ZEROIZE_EN
      .zeroize          (zeroize),
`endif
      .round_key_output (round_key_output),
      .round_key_0      (round_key_0),
      .key_ready        (key_ready),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                 ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic model(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
            tmp = tmp ^ {rc, 24'h0};
            rc  = xtime(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++)
         exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [127:0] k);
      key_in   = k;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
   endtask

   // n counts edges including the load edge
   task automatic wait_ready();
      int n, nb;
      n  = 1;
      nb = 0;
      while (!key_ready && n < 40) begin
         if (busy) nb++;
         tick();
         n++;
      end
      check("latency", 128'(n), 128'(11));
      check("busy_cycles", 128'(nb), 128'(10));
      check("busy_done", 128'(busy), 128'(0));
   endtask

   task automatic check_keys(input string tag, input logic [127:0] key);
      model(key);
      check({tag, "_rk0"}, round_key_0, key);
      for (int a = 0; a < 16; a++) begin
         read_addr = 4'(a);
         #1;
         check(tag, round_key_output, (a <= 10) ? exp_rk[a] : 128'h0);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      n_rst     = 1'b0;
      key_load  = 1'b0;
      key_in    = '0;
      read_addr = '0;
`ifdef KEY_SCHEDULE_ZEROIZE_EN
      zeroize   = 1'b0;
`endif
      build_sbox();
      #12;
      for (int a = 0; a < 16; a++) begin
         read_addr = 4'(a);
         #1;
         check("rst_read", round_key_output, 128'h0);
      end
      check("rst_ready", 128'(key_ready), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_rk0", round_key_0, 128'h0);
      n_rst = 1'b1;
      tick();

      load(128'h2b7e151628aed2a6abf7158809cf4f3c);
      check("busy_start", 128'(busy), 128'(1));
      wait_ready();
      check_keys("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c);
      read_addr = 4'd1;
      #1;
      check("fips_a1", round_key_output, 128'ha0fafe1788542cb123a339392a6c7605);
      read_addr = 4'd10;
      #1;
      check("fips_a10", round_key_output, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      load(rnd128());
      for (int i = 0; i < 4; i++) tick();
      load(128'h0);
      wait_ready();
      check_keys("abort", 128'h0);
      read_addr = 4'd1;
      #1;
      check("zero_a1", round_key_output, 128'h62636363626363636263636362636363);
      read_addr = 4'd10;
      #1;
      check("zero_a10", round_key_output, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      load(rnd128());
      for (int i = 0; i < 3; i++) tick();
      #2;
      n_rst = 1'b0;
      #1;
      check("arst_busy", 128'(busy), 128'(0));
      check("arst_ready", 128'(key_ready), 128'(0));
      check("arst_rk0", round_key_0, 128'h0);
      read_addr = 4'd0;
      #0.5;
      check("arst_a0", round_key_output, 128'h0);
      read_addr = 4'd1;
      #0.5;
      check("arst_a1", round_key_output, 128'h0);
      tick();
      n_rst = 1'b1;
      tick();
      key_in = rnd128();
      load(key_in);
      wait_ready();
      check_keys("post_rst", key_in);

      key_in = rnd128();
      load(key_in);
      check("reload_drop", 128'(key_ready), 128'(0));
      wait_ready();
      check_keys("reload", key_in);

      for (int r = 0; r < 4; r++) begin
         key_in = rnd128();
         load(key_in);
         wait_ready();
         check_keys("rand", key_in);
      end

`ifdef KEY_SCHEDULE_ZEROIZE_EN
      key_in   = rnd128();
      zeroize  = 1'b1;
      key_load = 1'b1;
      tick();
      zeroize  = 1'b0;
      key_load = 1'b0;
      check("zz_ready", 128'(key_ready), 128'(0));
      check("zz_busy", 128'(busy), 128'(0));
      check("zz_rk0", round_key_0, 128'h0);
      for (int a = 0; a < 16; a++) begin
         read_addr = 4'(a);
         #1;
         check("zz_read", round_key_output, 128'h0);
      end
      tick();
      check("zz_idle", 128'(busy), 128'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
